// File: rtl/arm_imm_encoder.sv
// Searches for the lowest-rotation ARM data-processing immediate {rot, imm8}
// that expands to a captured 32-bit constant, PER_CYCLE rotations per cycle.
module arm_imm_encoder #(
    parameter int PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_ok,
    output logic [11:0] out_imm12
);

    typedef enum logic [1:0] {IDLE, SEARCH, RESULT} state_t;

    state_t      state_q, state_d;
    logic [31:0] value_q, value_d;
    logic [4:0]  rot_base_q, rot_base_d;
    logic        ok_q, ok_d;
    logic [11:0] imm12_q, imm12_d;

    if (PER_CYCLE != 1 && PER_CYCLE != 2 && PER_CYCLE != 4 &&
        PER_CYCLE != 8 && PER_CYCLE != 16) begin : g_bad_per_cycle
        $error("arm_imm_encoder: PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    logic [PER_CYCLE-1:0] hit;
    logic [31:0]          cand    [PER_CYCLE];
    logic [3:0]           rot_idx [PER_CYCLE];

    // One rotate-left-by-2r candidate per lane of the current group.
    for (genvar gi = 0; gi < PER_CYCLE; gi++) begin : g_lane
        logic [4:0] shamt;
        assign rot_idx[gi] = rot_base_q[3:0] + 4'(gi);
        assign shamt       = {rot_idx[gi], 1'b0};
        assign cand[gi]    = (value_q << shamt) | (value_q >> (6'd32 - {1'b0, shamt}));
        assign hit[gi]     = (cand[gi][31:8] == 24'd0);
    end

    logic        sel_hit;
    logic [11:0] sel_imm;
    logic        last_group;

    // Scan from the top lane down so the lowest hitting rotation wins.
    always_comb begin
        sel_hit = 1'b0;
        sel_imm = 12'h000;
        for (int i = PER_CYCLE - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel_hit = 1'b1;
                sel_imm = {rot_idx[i], cand[i][7:0]};
            end
        end
    end

    assign last_group = ((rot_base_q + 5'(PER_CYCLE)) == 5'd16);

    always_comb begin
        state_d    = state_q;
        value_d    = value_q;
        rot_base_d = rot_base_q;
        ok_d       = ok_q;
        imm12_d    = imm12_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    value_d    = in_value;
                    rot_base_d = 5'd0;
                    ok_d       = 1'b0;
                    imm12_d    = 12'h000;
                    state_d    = SEARCH;
                end
            end
            SEARCH: begin
                if (sel_hit) begin
                    ok_d    = 1'b1;
                    imm12_d = sel_imm;
                    state_d = RESULT;
                end else if (last_group) begin
                    ok_d    = 1'b0;
                    imm12_d = 12'h000;
                    state_d = RESULT;
                end else begin
                    rot_base_d = rot_base_q + 5'(PER_CYCLE);
                end
            end
            RESULT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            value_q    <= 32'd0;
            rot_base_q <= 5'd0;
            ok_q       <= 1'b0;
            imm12_q    <= 12'h000;
        end else begin
            state_q    <= state_d;
            value_q    <= value_d;
            rot_base_q <= rot_base_d;
            ok_q       <= ok_d;
            imm12_q    <= imm12_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == RESULT);
    assign out_ok    = ok_q;
    assign out_imm12 = imm12_q;

endmodule

// File: tb/tb_arm_imm_encoder.sv
// Directed and randomised checks of arm_imm_encoder with PER_CYCLE=1 (dut 0)
// and PER_CYCLE=4 (dut 1).
module tb_arm_imm_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid_a  [2];
    logic        in_ready_a  [2];
    logic [31:0] in_value_a  [2];
    logic        out_valid_a [2];
    logic        out_ready_a [2];
    logic        out_ok_a    [2];
    logic [11:0] out_imm12_a [2];

    int checks = 0;
    int errors = 0;

    arm_imm_encoder #(.PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]), .in_value(in_value_a[0]),
        .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]),
        .out_ok(out_ok_a[0]), .out_imm12(out_imm12_a[0])
    );

    arm_imm_encoder #(.PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]), .in_value(in_value_a[1]),
        .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]),
        .out_ok(out_ok_a[1]), .out_imm12(out_imm12_a[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rol32(input logic [31:0] v, input int s);
        logic [31:0] r;
        r = v;
        for (int k = 0; k < s; k++) r = {r[30:0], r[31]};
        return r;
    endfunction

    function automatic logic [31:0] ror32(input logic [31:0] v, input int s);
        logic [31:0] r;
        r = v;
        for (int k = 0; k < s; k++) r = {r[0], r[31:1]};
        return r;
    endfunction

    // Reference: lowest rotation whose rotate-left result fits in 8 bits.
    task automatic ref_enc(input logic [31:0] v, output logic ok, output logic [11:0] imm, output int rot);
        logic [31:0] c;
        ok  = 1'b0;
        imm = 12'h000;
        rot = 16;
        for (int r = 15; r >= 0; r--) begin
            c = rol32(v, 2 * r);
            if (c[31:8] == 24'd0) begin
                ok  = 1'b1;
                imm = {4'(r), c[7:0]};
                rot = r;
            end
        end
    endtask

    // Issue one request; returns result and latency in the T+n convention.
    task automatic do_req(input int s, input logic [31:0] val, input int hold, input bit noise,
                          output logic ok, output logic [11:0] imm, output int lat);
        int edges;
        @(posedge clk); #1;
        chk("idle_in_ready", 32'(in_ready_a[s]), 32'd1);
        in_valid_a[s]  = 1'b1;
        in_value_a[s]  = val;
        out_ready_a[s] = 1'b0;
        @(posedge clk); #1;
        in_valid_a[s] = 1'b0;
        in_value_a[s] = $urandom;
        edges = 0;
        while (!out_valid_a[s] && edges < 40) begin
            if (noise) begin
                chk("search_in_ready", 32'(in_ready_a[s]), 32'd0);
                in_valid_a[s] = ~in_valid_a[s];
                in_value_a[s] = $urandom;
            end
            @(posedge clk); #1;
            edges++;
        end
        in_valid_a[s] = 1'b0;
        chk("timeout", 32'(edges < 40), 32'd1);
        lat = edges + 1;
        ok  = out_ok_a[s];
        imm = out_imm12_a[s];
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(out_valid_a[s]), 32'd1);
            chk("hold_ok", 32'(out_ok_a[s]), 32'(ok));
            chk("hold_imm", 32'(out_imm12_a[s]), 32'(imm));
            chk("hold_in_ready", 32'(in_ready_a[s]), 32'd0);
        end
        out_ready_a[s] = 1'b1;
        @(posedge clk); #1;
        out_ready_a[s] = 1'b0;
        chk("post_valid", 32'(out_valid_a[s]), 32'd0);
        chk("post_in_ready", 32'(in_ready_a[s]), 32'd1);
    endtask

    task automatic directed(input int s, input logic [31:0] val, input int hold, input bit noise,
                            input logic exp_ok, input logic [11:0] exp_imm, input int exp_lat);
        logic ok;
        logic [11:0] imm;
        int lat;
        do_req(s, val, hold, noise, ok, imm, lat);
        $display("dut%0d val=%h ok=%0d imm12=%h lat=T+%0d", s, val, ok, imm, lat);
        chk("ok", 32'(ok), 32'(exp_ok));
        chk("imm12", 32'(imm), 32'(exp_imm));
        chk("latency", 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        logic ok, rok;
        logic [11:0] imm, rimm;
        logic [31:0] v;
        int lat, rrot, per, exp_lat;

        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            in_valid_a[s]  = 1'b0;
            in_value_a[s]  = 32'd0;
            out_ready_a[s] = 1'b0;
        end
        #2;
        for (int s = 0; s < 2; s++) begin
            chk("rst_in_ready", 32'(in_ready_a[s]), 32'd1);
            chk("rst_out_valid", 32'(out_valid_a[s]), 32'd0);
            chk("rst_out_ok", 32'(out_ok_a[s]), 32'd0);
            chk("rst_imm12", 32'(out_imm12_a[s]), 32'd0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        directed(0, 32'h000000FF, 0, 0, 1'b1, 12'h0FF, 2);
        directed(0, 32'h00000000, 0, 0, 1'b1, 12'h000, 2);
        directed(0, 32'hFF000000, 0, 0, 1'b1, 12'h4FF, 6);
        directed(0, 32'hF000000F, 0, 0, 1'b1, 12'h2FF, 4);
        directed(0, 32'h000003FC, 0, 0, 1'b1, 12'hFFF, 17);
        directed(0, 32'h00000101, 0, 0, 1'b0, 12'h000, 17);
        directed(0, 32'hFF000000, 3, 1, 1'b1, 12'h4FF, 6);
        directed(1, 32'h000003FC, 0, 0, 1'b1, 12'hFFF, 5);
        directed(1, 32'h00000101, 0, 0, 1'b0, 12'h000, 5);
        directed(1, 32'hF000000F, 2, 1, 1'b1, 12'h2FF, 2);

        // Reset during search of a non-encodable value.
        @(posedge clk); #1;
        in_valid_a[0] = 1'b1;
        in_value_a[0] = 32'h00000101;
        @(posedge clk); #1;
        in_valid_a[0] = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("mid_search_in_ready", 32'(in_ready_a[0]), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_search_valid", 32'(out_valid_a[0]), 32'd0);
        chk("rst_search_in_ready", 32'(in_ready_a[0]), 32'd1);
        @(negedge clk) rst_n = 1'b1;
        $display("dut0 reset during search");
        directed(0, 32'h000000FF, 0, 0, 1'b1, 12'h0FF, 2);

        // Reset while a result is pending.
        @(posedge clk); #1;
        in_valid_a[0] = 1'b1;
        in_value_a[0] = 32'hFF000000;
        @(posedge clk); #1;
        in_valid_a[0] = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        chk("pend_valid", 32'(out_valid_a[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_result_valid", 32'(out_valid_a[0]), 32'd0);
        chk("rst_result_ok", 32'(out_ok_a[0]), 32'd0);
        chk("rst_result_imm", 32'(out_imm12_a[0]), 32'd0);
        chk("rst_result_in_ready", 32'(in_ready_a[0]), 32'd1);
        @(negedge clk) rst_n = 1'b1;
        $display("dut0 reset during result");
        directed(0, 32'h00000000, 0, 0, 1'b1, 12'h000, 2);

        // Randomised regression against the reference model.
        for (int i = 0; i < 1700; i++) begin
            int s;
            s   = (i < 200) ? 0 : 1;
            per = (s == 0) ? 1 : 4;
            if (i % 2 == 0) v = ror32(32'($urandom_range(255, 0)), 2 * $urandom_range(15, 0));
            else            v = $urandom;
            ref_enc(v, rok, rimm, rrot);
            exp_lat = rok ? (2 + rrot / per) : (1 + 16 / per);
            do_req(s, v, 0, 0, ok, imm, lat);
            $display("rand dut%0d val=%h ok=%0d imm12=%h lat=T+%0d", s, v, ok, imm, lat);
            chk("rand_ok", 32'(ok), 32'(rok));
            chk("rand_imm12", 32'(imm), 32'(rimm));
            chk("rand_latency", 32'(lat), 32'(exp_lat));
            if (ok) chk("rand_expand", ror32({24'd0, imm[7:0]}, 2 * int'(imm[11:8])), v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
